// File: rtl/sys_defs.sv
// Shared processor-level definitions: memory bus commands, load-tag owner
// identifiers and the size of the memory tag space.
package sys_defs;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } bus_command_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } mem_owner_t;

  // Memory tags are 4 bits wide; tag 0 means "no tag", so 15 are usable.
  localparam int unsigned NumTags = 15;

endpackage

// File: rtl/tag_owner_table.sv
// Tracks which cache owns each in-flight memory load tag (1..15).
// Ports:
//   clock, reset          : clock and synchronous active-high reset
//   alloc_en_i/tag/owner  : record a newly accepted load at the clock edge
//   free_en_i, free_tag_i : returning tag; cleared at the edge if valid
//   rd_valid_o/rd_owner_o : registered valid/owner of free_tag_i
//   i_count_o, d_count_o  : number of valid entries per owner
//   collision_o           : sticky, set when alloc hits an already valid entry
module tag_owner_table
  import sys_defs::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       alloc_en_i,
  input  logic [3:0] alloc_tag_i,
  input  mem_owner_t alloc_owner_i,
  input  logic       free_en_i,
  input  logic [3:0] free_tag_i,
  output logic       rd_valid_o,
  output mem_owner_t rd_owner_o,
  output logic [3:0] i_count_o,
  output logic [3:0] d_count_o,
  output logic       collision_o
);

  logic [NumTags:1] valid_q, valid_d;
  // One bit per entry: 0 = OWN_I, 1 = OWN_D.
  logic [NumTags:1] own_q, own_d;
  logic             err_q, err_d;

  always_comb begin
    valid_d    = valid_q;
    own_d      = own_q;
    err_d      = err_q;
    rd_valid_o = 1'b0;
    rd_owner_o = OWN_I;
    i_count_o  = '0;
    d_count_o  = '0;
    for (int unsigned i = 1; i <= NumTags; i++) begin
      if (free_tag_i == 4'(i)) begin
        rd_valid_o = valid_q[i];
        rd_owner_o = mem_owner_t'(own_q[i]);
        if (free_en_i) valid_d[i] = 1'b0;
      end
      // Applied after the free so a same-tag allocate leaves the entry valid.
      if (alloc_en_i && (alloc_tag_i == 4'(i))) begin
        if (valid_q[i]) err_d = 1'b1;
        valid_d[i] = 1'b1;
        own_d[i]   = alloc_owner_i;
      end
      i_count_o = i_count_o + 4'(valid_q[i] & ~own_q[i]);
      d_count_o = d_count_o + 4'(valid_q[i] & own_q[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      own_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      own_q   <= own_d;
      err_q   <= err_d;
    end
  end

  assign collision_o = err_q;

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single processor-memory bus port between icache and dcache.
// Grants at most one requester per cycle (dcache preferred, icache after
// STARVE_LIMIT consecutive losses), forwards its command and the memory
// accept response, and steers returning load tags/data to their owner.
// Ports:
//   clock, reset                   : clock, synchronous active-high reset
//   Icache2arb_*, Dcache2arb_*     : requester commands, addresses, store data
//   Imem2proc_*, Dmem2proc_*       : per-cache response, return tag, data
//   proc2mem_*                     : command/addr/data to memory
//   mem2proc_*                     : memory accept tag, return tag, data
//   i_outstanding, d_outstanding   : in-flight loads per owner
//   tag_error                      : sticky duplicate-tag allocation flag
module mem_arbiter
  import sys_defs::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  bus_command_t Icache2arb_command,
  input  logic [31:0]  Icache2arb_addr,
  input  bus_command_t Dcache2arb_command,
  input  logic [31:0]  Dcache2arb_addr,
  input  logic [63:0]  Dcache2arb_data,
  output logic [3:0]   Imem2proc_response,
  output logic [3:0]   Imem2proc_tag,
  output logic [63:0]  Imem2proc_data,
  output logic [3:0]   Dmem2proc_response,
  output logic [3:0]   Dmem2proc_tag,
  output logic [63:0]  Dmem2proc_data,
  output bus_command_t proc2mem_command,
  output logic [31:0]  proc2mem_addr,
  output logic [63:0]  proc2mem_data,
  input  logic [3:0]   mem2proc_response,
  input  logic [3:0]   mem2proc_tag,
  input  logic [63:0]  mem2proc_data,
  output logic [3:0]   i_outstanding,
  output logic [3:0]   d_outstanding,
  output logic         tag_error
);

  localparam int unsigned StarveW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

  logic [StarveW-1:0] starve_q, starve_d;
  logic               i_act, d_act, grant_i, grant_d;
  logic               alloc_en, ret_hit;
  mem_owner_t         alloc_owner, rd_owner;
  logic               rd_valid;

  always_comb begin
    i_act   = (Icache2arb_command != BUS_NONE);
    d_act   = (Dcache2arb_command != BUS_NONE);
    grant_i = !reset && i_act && (!d_act || (starve_q == StarveMax));
    grant_d = !reset && d_act && !grant_i;

    starve_d = '0;
    if (!reset && i_act && !grant_i) begin
      starve_d = (starve_q == StarveMax) ? starve_q : starve_q + 1'b1;
    end

    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    if (grant_i) begin
      proc2mem_command = Icache2arb_command;
      proc2mem_addr    = Icache2arb_addr;
    end else if (grant_d) begin
      proc2mem_command = Dcache2arb_command;
      proc2mem_addr    = Dcache2arb_addr;
      proc2mem_data    = Dcache2arb_data;
    end

    Imem2proc_response = grant_i ? mem2proc_response : 4'h0;
    Dmem2proc_response = grant_d ? mem2proc_response : 4'h0;

    // Stores carry no return tag, so only accepted loads allocate.
    alloc_en    = (grant_i || grant_d) && (proc2mem_command == BUS_LOAD) &&
                  (mem2proc_response != 4'h0);
    alloc_owner = grant_i ? OWN_I : OWN_D;

    // Unknown tags (never allocated, or forgotten by reset) are dropped.
    ret_hit       = !reset && (mem2proc_tag != 4'h0) && rd_valid;
    Imem2proc_tag = (ret_hit && (rd_owner == OWN_I)) ? mem2proc_tag : 4'h0;
    Dmem2proc_tag = (ret_hit && (rd_owner == OWN_D)) ? mem2proc_tag : 4'h0;
  end

  assign Imem2proc_data = mem2proc_data;
  assign Dmem2proc_data = mem2proc_data;

  always_ff @(posedge clock) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end

  tag_owner_table u_table (
    .clock         (clock),
    .reset         (reset),
    .alloc_en_i    (alloc_en),
    .alloc_tag_i   (mem2proc_response),
    .alloc_owner_i (alloc_owner),
    .free_en_i     (mem2proc_tag != 4'h0),
    .free_tag_i    (mem2proc_tag),
    .rd_valid_o    (rd_valid),
    .rd_owner_o    (rd_owner),
    .i_count_o     (i_outstanding),
    .d_count_o     (d_outstanding),
    .collision_o   (tag_error)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import sys_defs::*;

  localparam int Limit = 4;

  logic         clock = 1'b0;
  logic         reset;
  bus_command_t ic_cmd, dc_cmd;
  logic [31:0]  ic_addr, dc_addr;
  logic [63:0]  dc_data;
  logic [3:0]   i_resp, i_tag, d_resp, d_tag;
  logic [63:0]  i_data, d_data;
  bus_command_t p2m_cmd;
  logic [31:0]  p2m_addr;
  logic [63:0]  p2m_data;
  logic [3:0]   m_resp, m_tag;
  logic [63:0]  m_data;
  logic [3:0]   i_out, d_out;
  logic         t_err;

  mem_arbiter #(.STARVE_LIMIT(Limit)) dut (
    .clock              (clock),
    .reset              (reset),
    .Icache2arb_command (ic_cmd),
    .Icache2arb_addr    (ic_addr),
    .Dcache2arb_command (dc_cmd),
    .Dcache2arb_addr    (dc_addr),
    .Dcache2arb_data    (dc_data),
    .Imem2proc_response (i_resp),
    .Imem2proc_tag      (i_tag),
    .Imem2proc_data     (i_data),
    .Dmem2proc_response (d_resp),
    .Dmem2proc_tag      (d_tag),
    .Dmem2proc_data     (d_data),
    .proc2mem_command   (p2m_cmd),
    .proc2mem_addr      (p2m_addr),
    .proc2mem_data      (p2m_data),
    .mem2proc_response  (m_resp),
    .mem2proc_tag       (m_tag),
    .mem2proc_data      (m_data),
    .i_outstanding      (i_out),
    .d_outstanding      (d_out),
    .tag_error          (t_err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] tag;
    mem_owner_t owner;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   starve_m = 0;
  logic err_m = 1'b0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic logic [3:0] cnt_owner(input mem_owner_t o);
    logic [3:0] n = 4'h0;
    foreach (sb[k]) if (sb[k].owner == o) n = n + 4'h1;
    return n;
  endfunction

  function automatic int find_tag(input logic [3:0] t);
    foreach (sb[k]) if (sb[k].tag == t) return k;
    return -1;
  endfunction

  task automatic check_state(input string where);
    check({where, ":i_outstanding"}, 64'(i_out), 64'(cnt_owner(OWN_I)));
    check({where, ":d_outstanding"}, 64'(d_out), 64'(cnt_owner(OWN_D)));
    check({where, ":tag_error"}, 64'(t_err), 64'(err_m));
  endtask

  // One request cycle: drive, check combinational forwarding, update model.
  task automatic req(input string where, input bus_command_t ic, input logic [31:0] ia,
                     input bus_command_t dc, input logic [31:0] da, input logic [63:0] dd,
                     input logic [3:0] resp);
    bit           ia_act, da_act, win_i, win_d;
    bus_command_t e_cmd;
    logic [31:0]  e_addr;
    logic [63:0]  e_data;
    int           idx;
    ic_cmd = ic; ic_addr = ia; dc_cmd = dc; dc_addr = da; dc_data = dd;
    m_resp = resp; m_tag = 4'h0; m_data = 64'h0;
    #1;
    ia_act = (ic != BUS_NONE);
    da_act = (dc != BUS_NONE);
    win_i  = ia_act && (!da_act || starve_m == Limit);
    win_d  = da_act && !win_i;
    e_cmd  = win_i ? ic : (win_d ? dc : BUS_NONE);
    e_addr = win_i ? ia : (win_d ? da : 32'h0);
    e_data = win_d ? dd : 64'h0;
    check({where, ":p2m_cmd"}, 64'(p2m_cmd), 64'(e_cmd));
    check({where, ":p2m_addr"}, 64'(p2m_addr), 64'(e_addr));
    check({where, ":p2m_data"}, p2m_data, e_data);
    check({where, ":i_resp"}, 64'(i_resp), win_i ? 64'(resp) : 64'h0);
    check({where, ":d_resp"}, 64'(d_resp), win_d ? 64'(resp) : 64'h0);
    if (e_cmd == BUS_LOAD && resp != 4'h0) begin
      idx = find_tag(resp);
      if (idx >= 0) begin
        err_m = 1'b1;
        sb.delete(idx);
      end
      sb.push_back('{tag: resp, owner: win_i ? OWN_I : OWN_D});
    end
    if (ia_act && !win_i) starve_m = (starve_m < Limit) ? starve_m + 1 : Limit;
    else starve_m = 0;
    tick();
    check_state(where);
  endtask

  // One return cycle: memory presents a tag; scoreboard says who owns it.
  task automatic ret(input string where, input logic [3:0] t, input logic [63:0] dat);
    int       idx;
    exp_t     e;
    ic_cmd = BUS_NONE; dc_cmd = BUS_NONE; m_resp = 4'h0;
    m_tag = t; m_data = dat;
    #1;
    idx = find_tag(t);
    e   = (idx >= 0) ? sb[idx] : '{tag: 4'h0, owner: OWN_I};
    check({where, ":i_tag"}, 64'(i_tag), (idx >= 0 && e.owner == OWN_I) ? 64'(t) : 64'h0);
    check({where, ":d_tag"}, 64'(d_tag), (idx >= 0 && e.owner == OWN_D) ? 64'(t) : 64'h0);
    check({where, ":i_data"}, i_data, dat);
    check({where, ":d_data"}, d_data, dat);
    if (idx >= 0) sb.delete(idx);
    starve_m = 0;
    tick();
    check_state(where);
  endtask

  task automatic idle();
    ic_cmd = BUS_NONE; dc_cmd = BUS_NONE; m_resp = 4'h0; m_tag = 4'h0; m_data = 64'h0;
    starve_m = 0;
    tick();
  endtask

  initial begin
    // Reset with live requests and a stray return: everything must be quiet.
    reset = 1'b1;
    ic_cmd = BUS_LOAD; ic_addr = 32'h40; dc_cmd = BUS_STORE; dc_addr = 32'h80;
    dc_data = 64'h1; m_resp = 4'h3; m_tag = 4'h3; m_data = 64'h0;
    tick();
    tick();
    check("rst:p2m_cmd", 64'(p2m_cmd), 64'(BUS_NONE));
    check("rst:i_resp", 64'(i_resp), 64'h0);
    check("rst:d_resp", 64'(d_resp), 64'h0);
    check("rst:i_tag", 64'(i_tag), 64'h0);
    check("rst:d_tag", 64'(d_tag), 64'h0);
    check_state("rst");
    reset = 1'b0;
    idle();

    // Icache-only load, returned two cycles after acceptance.
    req("t1_load", BUS_LOAD, 32'h100, BUS_NONE, 32'h0, 64'h0, 4'h3);
    idle();
    check_state("t1_wait");
    ret("t1_ret", 4'h3, 64'hDEAD_BEEF_0000_0003);

    // Both request every cycle: dcache stores win 4, icache load wins the 5th.
    for (int k = 0; k < 10; k++) begin
      req($sformatf("t2_c%0d", k), BUS_LOAD, 32'h1000 + 32'(8 * k), BUS_STORE,
          32'h2000 + 32'(8 * k), 64'hA000 + 64'(k), 4'(k + 1));
    end
    ret("t2_ret5", 4'h5, 64'h55);
    ret("t2_ret10", 4'hA, 64'hAA);

    // Store never allocates; the stray tag is dropped.
    req("t3_store", BUS_NONE, 32'h0, BUS_STORE, 32'h500, 64'h1234, 4'h5);
    ret("t3_stray", 4'h5, 64'h77);

    // Interleaved owners, returned out of order.
    req("t4_i7", BUS_LOAD, 32'h200, BUS_NONE, 32'h0, 64'h0, 4'h7);
    req("t4_d2", BUS_NONE, 32'h0, BUS_LOAD, 32'h300, 64'h0, 4'h2);
    ret("t4_ret2", 4'h2, 64'h2222);
    ret("t4_ret7", 4'h7, 64'h7777);

    // Duplicate allocation of tag 4: sticky error, new owner takes the entry.
    req("t5_i4", BUS_LOAD, 32'h400, BUS_NONE, 32'h0, 64'h0, 4'h4);
    req("t5_d4", BUS_NONE, 32'h0, BUS_LOAD, 32'h408, 64'h0, 4'h4);
    ret("t5_ret4", 4'h4, 64'h4444);
    idle();
    idle();
    check_state("t5_sticky");

    // Reset with three loads in flight; their returns must vanish.
    req("t6_i11", BUS_LOAD, 32'h600, BUS_NONE, 32'h0, 64'h0, 4'hB);
    req("t6_d12", BUS_NONE, 32'h0, BUS_LOAD, 32'h608, 64'h0, 4'hC);
    req("t6_i13", BUS_LOAD, 32'h610, BUS_NONE, 32'h0, 64'h0, 4'hD);
    reset = 1'b1;
    idle();
    sb.delete();
    err_m = 1'b0;
    check_state("t6_rst");
    reset = 1'b0;
    ret("t6_ret11", 4'hB, 64'hB);
    ret("t6_ret12", 4'hC, 64'hC);
    ret("t6_ret13", 4'hD, 64'hD);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single processor-memory bus port between the instruction cache and the data cache. Each cycle it grants at most one requester, forwards that requester's command to memory, and returns memory's accept response to it. It records which requester owns every accepted load tag and steers each returning tag and data to that owner. It sits between icache/dcache and the memory model at the top of the processor.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: consecutive lost arbitrations after which icache takes priority.

Ports:
- `clock`  in  1: the single clock.
- `reset`  in  1: synchronous, active-high.
- `Icache2arb_command`  in  2: BUS_NONE or BUS_LOAD from icache.
- `Icache2arb_addr`  in  32: icache request address, 8-byte aligned.
- `Dcache2arb_command`  in  2: BUS_NONE, BUS_LOAD or BUS_STORE from dcache.
- `Dcache2arb_addr`  in  32: dcache request address.
- `Dcache2arb_data`  in  64: dcache store data.
- `Imem2proc_response`  out  4: accept tag to icache; 0 means rejected.
- `Imem2proc_tag`  out  4: returning tag to icache; 0 means none.
- `Imem2proc_data`  out  64: returning data to icache.
- `Dmem2proc_response`, `Dmem2proc_tag`, `Dmem2proc_data`  out  4/4/64: the same three signals for dcache.
- `proc2mem_command`  out  2: command to memory.
- `proc2mem_addr`  out  32: address to memory.
- `proc2mem_data`  out  64: store data to memory.
- `mem2proc_response`  in  4: memory accept tag; 0 means rejected.
- `mem2proc_tag`  in  4: memory return tag; 0 means none.
- `mem2proc_data`  in  64: memory return data.
- `i_outstanding`, `d_outstanding`  out  4: count of in-flight loads per owner.
- `tag_error`  out  1: sticky flag, set when a load allocates a tag that is already valid.

## Operation
- Grant rule (combinational):
  - Only one requester active (command != BUS_NONE): that requester wins.
  - Both active: dcache wins, unless `starve_cnt == STARVE_LIMIT`, in which case icache wins.
- `starve_cnt` (register):
  - Increments when icache is active and loses, saturating at STARVE_LIMIT.
  - Clears when icache is granted or icache is idle.
- Forwarding:
  - The winner's command, addr and data drive `proc2mem_*`. With no winner: BUS_NONE, addr 0, data 0.
  - The winner's `*mem2proc_response` equals `mem2proc_response`. The loser's response is 0, and the loser retries on its own.
- Allocation:
  - Condition: granted command is BUS_LOAD and `mem2proc_response != 0`.
  - Action: at the clock edge, entry[response] gets valid=1 and owner=winner.
  - If the entry was already valid, overwrite it and set `tag_error`.
  - Stores never allocate; memory returns no tag for stores.
- Return:
  - If `mem2proc_tag != 0` and entry[tag] is valid, drive the owner's `*mem2proc_tag` with the tag and clear the entry at the edge.
  - The non-owner sees tag 0.
  - `mem2proc_data` is broadcast to both data outputs.
  - A tag with no valid entry is dropped silently.
- Same-cycle allocate and free of one tag: allocation wins (entry ends valid with the new owner).
- Outstanding counts: number of valid entries per owner, range 0–15; updated with the table.
- Reset:
  - Clears the table, counts, `starve_cnt` and `tag_error`.
  - While `reset` is high, `proc2mem_command` is BUS_NONE and all response and tag outputs are 0.
  - Loads in flight at reset are forgotten; their returns are dropped.

## Timing
- Request path is zero latency: requester command to `proc2mem_*` and memory response to requester are same-cycle combinational.
- Table, counts, `starve_cnt` and `tag_error` update on `posedge clock`.
- Return steering is combinational from registered table state. Memory returns a tag no earlier than one cycle after accepting it; a same-cycle return is unsupported.
- Reset values: `i_outstanding = 0`, `d_outstanding = 0`, `tag_error = 0`, `proc2mem_command = BUS_NONE`, all `*mem2proc_response` and `*mem2proc_tag` = 0.

## Structure
- BUS_NONE, BUS_LOAD and BUS_STORE, plus a new `typedef enum logic {OWN_I, OWN_D} mem_owner_t`, live in the shared sys_defs package.
- Sub-module `tag_owner_table`:
  - Storage: 15 entries, each valid + mem_owner_t, for tags 1–15.
  - Ports: alloc port, free port, the valid/owner read for the return tag, per-owner counts, collision flag.
- `mem_arbiter` itself holds the grant logic, `starve_cnt` and the output muxing.

## Test plan
- Icache only, BUS_LOAD to 0x100, response 3, tag 3 returned two cycles later → `proc2mem_addr = 0x100`; `Imem2proc_response = 3`; `i_outstanding` goes 1 then 0; `Imem2proc_tag = 3`; `Dmem2proc_tag = 0`.
- Both request every cycle, memory always accepts → dcache wins 4 cycles, icache wins the 5th, and the pattern repeats; the loser's response is always 0.
- Dcache BUS_STORE, response 5, then a stray `mem2proc_tag = 5` → no allocation; both tag outputs 0; counts stay 0.
- Icache load gets tag 7, dcache load gets tag 2; memory returns 2 then 7 → `Dmem2proc_tag = 2` first, `Imem2proc_tag = 7` next; counts return to 0.
- Allocate tag 4 while tag 4 is still valid → `tag_error` goes to 1 and stays until reset; the entry's owner is the new requester.
- Reset asserted with 3 loads in flight, then their tags return → counts 0 after reset; returns dropped; all tag outputs 0.
